// File: rtl/marfifo_burst_reader_if.sv
// Bus bundle between the marga sample FIFO, the burst reader and the downstream stream packer.
//   fifo_*     : FIFO read side (data/valid/level/flags in, read strobe out)
//   flush_i    : request a burst of whatever is stored
//   m_t*       : valid/ready output stream with last-word marker
//   busy_o     : reader is not idle
//   err_o      : sticky unexpected-return flag
// Modport master is the reader's view; slave is the surrounding environment's view.
interface marfifo_burst_reader_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 32
);
  logic [WIDTH-1:0]          fifo_data_i;
  logic                      fifo_valid_i;
  logic [$clog2(LENGTH)-1:0] fifo_locs_i;
  logic                      fifo_empty_i;
  logic                      fifo_full_i;
  logic                      fifo_read_o;
  logic                      flush_i;
  logic [WIDTH-1:0]          m_tdata_o;
  logic                      m_tvalid_o;
  logic                      m_tready_i;
  logic                      m_tlast_o;
  logic                      busy_o;
  logic                      err_o;

  modport master (
    input  fifo_data_i, fifo_valid_i, fifo_locs_i, fifo_empty_i, fifo_full_i, flush_i,
    input  m_tready_i,
    output fifo_read_o, m_tdata_o, m_tvalid_o, m_tlast_o, busy_o, err_o
  );

  modport slave (
    output fifo_data_i, fifo_valid_i, fifo_locs_i, fifo_empty_i, fifo_full_i, flush_i,
    output m_tready_i,
    input  fifo_read_o, m_tdata_o, m_tvalid_o, m_tlast_o, busy_o, err_o
  );
endinterface

// File: rtl/marfifo_burst_reader.sv
// Burst drain stage for the marga sample FIFO. Waits for a full burst, a fill timeout or a
// flush, then strobes the FIFO up to n times, absorbs the read latency in a circular skid
// buffer and streams the words out with tlast on the n-th word.
// Ports:
//   clk     : system clock
//   rst     : asynchronous reset, active high
//   bus_if  : FIFO read side, flush request, output stream, busy/err status (master view)
module marfifo_burst_reader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned LENGTH     = 32,
  parameter int unsigned BURST      = 8,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned SKID_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  marfifo_burst_reader_if.master bus_if
);

  localparam int unsigned LocsW  = $clog2(LENGTH);
  localparam int unsigned AvailW = LocsW + 1;
  localparam int unsigned CntW   = $clog2(BURST + 1);
  localparam int unsigned PtrW   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int unsigned OccW   = $clog2(SKID_DEPTH + 1);
  localparam int unsigned SumW   = OccW + 1;
  localparam int unsigned TmoW   = $clog2(TIMEOUT + 2);

  localparam logic [AvailW-1:0] AvailFull = AvailW'(LENGTH);
  localparam logic [AvailW-1:0] BurstAv   = AvailW'(BURST);
  localparam logic [CntW-1:0]   BurstCnt  = CntW'(BURST);
  localparam logic [CntW-1:0]   CntOne    = CntW'(1);
  localparam logic [TmoW-1:0]   TmoMax    = TmoW'(TIMEOUT);
  localparam logic [TmoW-1:0]   TmoOne    = TmoW'(1);
  localparam logic [OccW-1:0]   OccOne    = OccW'(1);
  localparam logic [SumW-1:0]   SkidLim   = SumW'(SKID_DEPTH);
  localparam logic [PtrW-1:0]   PtrLast   = PtrW'(SKID_DEPTH - 1);
  localparam logic [PtrW-1:0]   PtrOne    = PtrW'(1);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   n_q, n_d;
  logic [CntW-1:0]   issued_q, issued_d;
  logic [CntW-1:0]   sent_q, sent_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [OccW-1:0]   in_flight_q, in_flight_d;
  logic [OccW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  mem_q [SKID_DEPTH];

  logic [AvailW-1:0] avail;
  logic [SumW-1:0]   occ;
  logic              trigger, rd_en, push, pop, stray, last_hs, tvalid;

  assign avail  = bus_if.fifo_full_i ? AvailFull : {1'b0, bus_if.fifo_locs_i};
  assign occ    = SumW'(count_q) + SumW'(in_flight_q);
  assign tvalid = (count_q != '0);
  assign pop    = tvalid && bus_if.m_tready_i;
  // Buffer only ever holds words of the current burst, so sent_q indexes the head word.
  assign last_hs = pop && (sent_q == n_q - CntOne);
  // A return with nothing outstanding cannot belong to us (e.g. left over across a reset).
  assign push    = bus_if.fifo_valid_i && (in_flight_q != '0);
  assign stray   = bus_if.fifo_valid_i && (in_flight_q == '0);
  assign trigger = (avail >= BurstAv)
                || (bus_if.flush_i && !bus_if.fifo_empty_i)
                || ((TIMEOUT != 0) && (tmo_q == TmoMax));

  // Burst control FSM
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    tmo_d    = tmo_q;
    rd_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus_if.fifo_empty_i) begin
          tmo_d = '0;
        end else if ((avail < BurstAv) && (tmo_q != TmoMax)) begin
          tmo_d = tmo_q + TmoOne;
        end
        if (trigger) begin
          state_d  = StRead;
          n_d      = (avail >= BurstAv) ? BurstCnt : CntW'(avail);
          issued_d = '0;
          sent_d   = '0;
          tmo_d    = '0;
        end
      end
      StRead: begin
        // Credit check covers both buffered words and reads still in the FIFO pipeline.
        rd_en = (issued_q < n_q) && !bus_if.fifo_empty_i && (occ < SkidLim) && !last_hs;
        if (rd_en) issued_d = issued_q + CntOne;
        if (pop) sent_d = sent_q + CntOne;
        if (last_hs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Skid buffer and outstanding-read bookkeeping
  always_comb begin
    in_flight_d = in_flight_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    err_d       = err_q | stray;
    unique case ({rd_en, push})
      2'b10:   in_flight_d = in_flight_q + OccOne;
      2'b01:   in_flight_d = in_flight_q - OccOne;
      default: in_flight_d = in_flight_q;
    endcase
    unique case ({push, pop})
      2'b10:   count_d = count_q + OccOne;
      2'b01:   count_d = count_q - OccOne;
      default: count_d = count_q;
    endcase
    if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      n_q         <= '0;
      issued_q    <= '0;
      sent_q      <= '0;
      tmo_q       <= '0;
      in_flight_q <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(SKID_DEPTH); i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      issued_q    <= issued_d;
      sent_q      <= sent_d;
      tmo_q       <= tmo_d;
      in_flight_q <= in_flight_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_q       <= err_d;
      if (push) mem_q[wr_ptr_q] <= bus_if.fifo_data_i;
    end
  end

  assign bus_if.fifo_read_o = rd_en;
  assign bus_if.m_tvalid_o  = tvalid;
  assign bus_if.m_tdata_o   = tvalid ? mem_q[rd_ptr_q] : '0;
  assign bus_if.m_tlast_o   = tvalid && (sent_q == n_q - CntOne);
  assign bus_if.busy_o      = (state_q != StIdle);
  assign bus_if.err_o       = err_q;

endmodule

// File: tb/tb_marfifo_burst_reader.sv
// Bench for marfifo_burst_reader: a queue-based FIFO with READ_LAT return pipeline feeds the
// DUT; a scoreboard of written words checks stream order, tlast placement and timing.
module tb_marfifo_burst_reader;
  localparam int unsigned Width     = 32;
  localparam int unsigned Length    = 32;
  localparam int unsigned Burst     = 8;
  localparam int unsigned ReadLat   = 1;
  localparam int unsigned SkidDepth = 4;
  localparam int unsigned Timeout   = 16;
  localparam int unsigned LocsW     = $clog2(Length);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  marfifo_burst_reader_if #(.WIDTH(Width), .LENGTH(Length)) bus ();

  marfifo_burst_reader #(
    .WIDTH(Width), .LENGTH(Length), .BURST(Burst), .READ_LAT(ReadLat),
    .SKID_DEPTH(SkidDepth), .TIMEOUT(Timeout)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_if(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference FIFO and scoreboard
  logic [Width-1:0] fifo_q[$];
  logic [Width-1:0] exp_q[$];
  logic             pipe_v [ReadLat];
  logic [Width-1:0] pipe_d [ReadLat];

  int cyc = 0;
  int mode = 0;  // 0: ready high, 1: ready toggles, 2: random ready
  bit rd_seen, flush_pend, stray_pend, saw_valid;
  int burst_k, n_rd, first_rd, last_rd, n_hs, first_hs, last_hs, first_v, first_busy;
  int busy_fall, outstanding, max_out, n_last;
  bit prev_stall, prev_l;
  logic [Width-1:0] prev_d;

  task automatic drive();
    bus.fifo_valid_i = pipe_v[0];
    bus.fifo_data_i  = pipe_d[0];
    if (stray_pend) begin
      bus.fifo_valid_i = 1'b1;
      bus.fifo_data_i  = 32'hdead_beef;
      stray_pend       = 1'b0;
    end
    bus.fifo_locs_i  = LocsW'(fifo_q.size());
    bus.fifo_empty_i = (fifo_q.size() == 0);
    bus.fifo_full_i  = (fifo_q.size() == Length);
    bus.flush_i      = flush_pend;
    flush_pend       = 1'b0;
    case (mode)
      0:       bus.m_tready_i = 1'b1;
      1:       bus.m_tready_i = cyc[0];
      default: bus.m_tready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic sample();
    bit exp_last;
    rd_seen = bus.fifo_read_o;
    if (rd_seen) begin
      n_rd++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
      outstanding++;
    end
    if (bus.busy_o && first_busy < 0) first_busy = cyc;
    if (!bus.busy_o && burst_k > 0 && n_hs == burst_k && busy_fall < 0) busy_fall = cyc;
    if (bus.m_tvalid_o) saw_valid = 1'b1;
    if (bus.m_tvalid_o && first_v < 0) first_v = cyc;
    if (prev_stall) begin
      check_eq("tvalid_hold", bus.m_tvalid_o, 1);
      check_eq("tdata_hold", bus.m_tdata_o, prev_d);
      check_eq("tlast_hold", bus.m_tlast_o, prev_l);
    end
    if (bus.m_tvalid_o && bus.m_tready_i) begin
      check_eq("hs_in_burst", n_hs < burst_k, 1);
      if (exp_q.size() > 0) check_eq("tdata", bus.m_tdata_o, exp_q.pop_front());
      // Bursts are full-size until the remainder, which goes out alone on timeout/flush.
      exp_last = ((n_hs % Burst) == Burst - 1) || (n_hs == burst_k - 1);
      check_eq("tlast", bus.m_tlast_o, exp_last);
      if (bus.m_tlast_o) n_last++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      n_hs++;
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
    prev_stall = bus.m_tvalid_o && !bus.m_tready_i;
    prev_d     = bus.m_tdata_o;
    prev_l     = bus.m_tlast_o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < int'(ReadLat) - 1; i++) begin
      pipe_v[i] = pipe_v[i+1];
      pipe_d[i] = pipe_d[i+1];
    end
    pipe_v[ReadLat-1] = 1'b0;
    pipe_d[ReadLat-1] = '0;
    if (rd_seen) begin
      if (fifo_q.size() == 0) begin
        check_eq("read_when_empty", fifo_q.size(), 1);
      end else begin
        pipe_v[ReadLat-1] = 1'b1;
        pipe_d[ReadLat-1] = fifo_q.pop_front();
      end
    end
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic clear_stats(input int k, input int md);
    burst_k = k; mode = md;
    n_rd = 0; first_rd = -1; last_rd = -1; n_hs = 0; first_hs = -1; last_hs = -1;
    first_v = -1; first_busy = -1; busy_fall = -1; outstanding = 0; max_out = 0; n_last = 0;
    saw_valid = 1'b0;
  endtask

  // Preload k words instantly, then drain until all k have been handshaken.
  task automatic run_burst(input string name, input int k, input logic [Width-1:0] base,
                           input int md, input bit flush, output int start);
    clear_stats(k, md);
    for (int i = 0; i < k; i++) begin
      fifo_q.push_back(base + Width'(i));
      exp_q.push_back(base + Width'(i));
    end
    flush_pend = flush;
    start = cyc + 1;
    for (int t = 0; t < 3000 && n_hs < k; t++) step();
    check_eq({name, "_words"}, n_hs, k);
    repeat (3) step();
    check_eq({name, "_fifo_empty"}, fifo_q.size(), 0);
    check_eq({name, "_busy_idle"}, bus.busy_o, 0);
    check_eq({name, "_skid_bound"}, max_out <= int'(SkidDepth), 1);
    check_eq({name, "_n_tlast"}, n_last, (k + Burst - 1) / Burst);
    check_eq({name, "_err"}, bus.err_o, 0);
  endtask

  initial begin
    int st;
    for (int i = 0; i < int'(ReadLat); i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
    rd_seen = 1'b0; flush_pend = 1'b0; stray_pend = 1'b0; prev_stall = 1'b0;
    prev_l = 1'b0; prev_d = '0;
    clear_stats(0, 0);
    rst = 1'b1;
    drive();
    #12;
    check_eq("rst_tvalid", bus.m_tvalid_o, 0);
    check_eq("rst_read", bus.fifo_read_o, 0);
    check_eq("rst_busy", bus.busy_o, 0);
    check_eq("rst_err", bus.err_o, 0);
    check_eq("rst_tdata", bus.m_tdata_o, 0);
    check_eq("rst_tlast", bus.m_tlast_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step();

    // Full burst, ready always high
    run_burst("t1", 8, 100, 0, 1'b0, st);
    check_eq("t1_busy_rise", first_busy - st, 1);
    check_eq("t1_first_read", first_rd - st, 1);
    check_eq("t1_reads", n_rd, 8);
    check_eq("t1_read_span", last_rd - first_rd, 7);
    check_eq("t1_first_valid", first_v - st, 2 + ReadLat);
    check_eq("t1_hs_span", last_hs - first_hs, 7);
    check_eq("t1_busy_fall", busy_fall - last_hs, 1);

    // Back-pressure by alternating ready
    run_burst("t2", 8, 100, 1, 1'b0, st);

    // Partial burst launched by the fill timeout
    run_burst("t3", 3, 300, 0, 1'b0, st);
    check_eq("t3_busy_rise", first_busy - st, Timeout + 1);

    // Single word launched by a flush pulse
    run_burst("t4", 1, 400, 0, 1'b1, st);
    check_eq("t4_busy_rise", first_busy - st, 1);
    check_eq("t4_first_valid", first_v - st, 2 + ReadLat);

    // Full FIFO drains as four bursts
    run_burst("t5", 32, 200, 0, 1'b0, st);

    // Random fill levels and random back-pressure
    for (int r = 0; r < 6; r++) begin
      run_burst("rnd", int'($urandom_range(1, Length)), $urandom, 2, 1'b0, st);
    end

    // Reset in the middle of a burst, then a stray return
    clear_stats(8, 0);
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(500 + i);
      exp_q.push_back(500 + i);
    end
    for (int t = 0; t < 200 && n_hs < 3; t++) step();
    check_eq("t6_sent_before_rst", n_hs, 3);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_tvalid", bus.m_tvalid_o, 0);
    check_eq("t6_rst_busy", bus.busy_o, 0);
    check_eq("t6_rst_read", bus.fifo_read_o, 0);
    check_eq("t6_rst_tdata", bus.m_tdata_o, 0);
    fifo_q.delete();
    exp_q.delete();
    for (int i = 0; i < int'(ReadLat); i++) pipe_v[i] = 1'b0;
    rd_seen = 1'b0;
    prev_stall = 1'b0;
    clear_stats(0, 0);
    repeat (2) step();
    rst = 1'b0;
    stray_pend = 1'b1;
    repeat (2) step();
    check_eq("t6_err_set", bus.err_o, 1);
    repeat (6) step();
    check_eq("t6_no_valid", saw_valid, 0);
    check_eq("t6_busy", bus.busy_o, 0);
    check_eq("t6_err_sticky", bus.err_o, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
